// File: rtl/gecko_mem_arbiter.sv
// Two-requester data-memory arbiter with in-order read-result routing back to the issuer.
// Define GECKO_MEM_ARBITER_FIXED_PRIORITY_EN to give requester 0 fixed priority instead of round-robin.
module gecko_mem_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    request0_valid,
  output logic                    request0_ready,
  input  logic                    request0_read_enable,
  input  logic [DATA_WIDTH/8-1:0] request0_write_enable,
  input  logic [ADDR_WIDTH-1:0]   request0_addr,
  input  logic [DATA_WIDTH-1:0]   request0_data,

  input  logic                    request1_valid,
  output logic                    request1_ready,
  input  logic                    request1_read_enable,
  input  logic [DATA_WIDTH/8-1:0] request1_write_enable,
  input  logic [ADDR_WIDTH-1:0]   request1_addr,
  input  logic [DATA_WIDTH-1:0]   request1_data,

  output logic                    mem_request_valid,
  input  logic                    mem_request_ready,
  output logic                    mem_request_read_enable,
  output logic [DATA_WIDTH/8-1:0] mem_request_write_enable,
  output logic [ADDR_WIDTH-1:0]   mem_request_addr,
  output logic [DATA_WIDTH-1:0]   mem_request_data,

  input  logic                    mem_result_valid,
  output logic                    mem_result_ready,
  input  logic [DATA_WIDTH-1:0]   mem_result_data,

  output logic                    result0_valid,
  input  logic                    result0_ready,
  output logic [DATA_WIDTH-1:0]   result0_data,

  output logic                    result1_valid,
  input  logic                    result1_ready,
  output logic [DATA_WIDTH-1:0]   result1_data
);

  localparam int unsigned MASK_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned PTR_WIDTH  = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CNT_WIDTH  = PTR_WIDTH + 1;

  logic [CNT_WIDTH-1:0]       count;
  logic [PTR_WIDTH-1:0]       wr_ptr;
  logic [PTR_WIDTH-1:0]       rd_ptr;
  logic [MAX_OUTSTANDING-1:0] order_ids;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       head_id;

  logic                  elig0;
  logic                  elig1;
  logic                  grant_valid;
  logic                  grant_id;
  logic                  stage_enable;
  logic                  accept;
  logic                  push;
  logic                  pop;
  logic                  sel_read;
  logic [MASK_WIDTH-1:0] sel_mask;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  assign fifo_full  = (count == CNT_WIDTH'(MAX_OUTSTANDING));
  assign fifo_empty = (count == '0);
  assign head_id    = order_ids[rd_ptr];

  // Reads are held off at full even when a pop lands in the same cycle.
  assign elig0 = request0_valid && (!request0_read_enable || !fifo_full);
  assign elig1 = request1_valid && (!request1_read_enable || !fifo_full);

`ifndef GECKO_MEM_ARBITER_FIXED_PRIORITY_EN
  logic last_grant;
`endif

  always_comb begin
    grant_valid = elig0 || elig1;
    grant_id    = 1'b0;
    if (elig0 && elig1) begin
`ifdef GECKO_MEM_ARBITER_FIXED_PRIORITY_EN
      grant_id = 1'b0;
`else
      grant_id = ~last_grant;
`endif
    end else if (elig1) begin
      grant_id = 1'b1;
    end
  end

  // Output stage takes a beat when empty or draining this cycle.
  assign stage_enable   = !mem_request_valid || mem_request_ready;
  assign accept         = grant_valid && stage_enable && !rst;
  assign request0_ready = accept && !grant_id;
  assign request1_ready = accept && grant_id;

  assign sel_read = grant_id ? request1_read_enable  : request0_read_enable;
  assign sel_mask = grant_id ? request1_write_enable : request0_write_enable;
  assign sel_addr = grant_id ? request1_addr         : request0_addr;
  assign sel_data = grant_id ? request1_data         : request0_data;

  assign push = accept && sel_read;
  assign pop  = mem_result_valid && mem_result_ready;

  // Results go straight to the requester at the head of the order FIFO.
  assign mem_result_ready = !rst && !fifo_empty && (head_id ? result1_ready : result0_ready);
  assign result0_valid    = !rst && !fifo_empty && !head_id && mem_result_valid;
  assign result1_valid    = !rst && !fifo_empty && head_id && mem_result_valid;
  assign result0_data     = mem_result_data;
  assign result1_data     = mem_result_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_request_valid        <= 1'b0;
      mem_request_read_enable  <= 1'b0;
      mem_request_write_enable <= '0;
      mem_request_addr         <= '0;
      mem_request_data         <= '0;
    end else if (stage_enable) begin
      mem_request_valid <= accept;
      if (accept) begin
        mem_request_read_enable  <= sel_read;
        mem_request_write_enable <= sel_mask;
        mem_request_addr         <= sel_addr;
        mem_request_data         <= sel_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      order_ids <= '0;
    end else begin
      if (push) begin
        order_ids[wr_ptr] <= grant_id;
        wr_ptr            <= wr_ptr + PTR_WIDTH'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_WIDTH'(1);
      end
      count <= count + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
    end
  end

`ifndef GECKO_MEM_ARBITER_FIXED_PRIORITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= grant_id;
    end
  end
`endif

endmodule
